// File: rtl/sspi_byte_slave.sv
// SPI mode-0 byte slave: oversamples CS/SCLK/MOSI into the clk domain, assembles
// MOSI bytes with a valid strobe and serialises a supplied byte onto MISO.
`timescale 1ns/1ps
module sspi_byte_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sspi_cs,
    input  logic       sspi_clk,
    input  logic       sspi_mosi,
    output logic       sspi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       cs_start,
    output logic       cs_end
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_mosi_sync;
    logic                   r_cs_d, r_sck_d;
    state_t                 r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx_sh;
    logic [6:0]             r_tx_sh;
    logic                   r_first;
    logic                   r_miso;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid, r_rx_first, r_tx_req, r_cs_start, r_cs_end;

    logic       w_cs, w_sck, w_mosi;
    logic       w_cs_fall, w_cs_rise, w_sck_rise;
    logic [7:0] w_rx_next;

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_d & ~w_cs;
    assign w_cs_rise  = ~r_cs_d & w_cs;
    assign w_sck_rise = ~r_sck_d & w_sck;
    assign w_rx_next  = {r_rx_sh, w_mosi};

    // Synchronisers reset to the bus idle levels so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], sspi_cs};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sspi_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], sspi_mosi};
            r_cs_d      <= w_cs;
            r_sck_d     <= w_sck;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_sh    <= 7'd0;
            r_tx_sh    <= 7'd0;
            r_first    <= 1'b1;
            r_miso     <= MISO_IDLE;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            r_cs_start <= 1'b0;
            r_cs_end   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            r_cs_start <= 1'b0;
            r_cs_end   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_miso <= MISO_IDLE;
                    if (w_cs_fall) begin
                        r_state    <= ACTIVE;
                        r_cs_start <= 1'b1;
                        r_tx_req   <= 1'b1;
                        r_bit_cnt  <= 3'd0;
                        r_first    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // tx_data is captured at the end of the cycle tx_req is high
                    if (r_tx_req) begin
                        r_tx_sh <= tx_data[6:0];
                        r_miso  <= tx_data[7];
                    end
                    if (w_sck_rise) begin
                        r_rx_sh   <= w_rx_next[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_rx_first <= r_first;
                            r_first    <= 1'b0;
                            r_tx_req   <= ~w_cs_rise;
                        end else begin
                            r_miso  <= r_tx_sh[6];
                            r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                        end
                    end
                    if (w_cs_rise) begin
                        r_state  <= IDLE;
                        r_cs_end <= 1'b1;
                        r_miso   <= MISO_IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sspi_miso = r_miso;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_first  = r_rx_first;
    assign tx_req    = r_tx_req;
    assign cs_start  = r_cs_start;
    assign cs_end    = r_cs_end;

endmodule

// File: tb/tb_sspi_byte_slave.sv
// Directed bench for sspi_byte_slave: a bit-banged SPI master drives frames and a
// scoreboard queue holds the expected {first, byte} for each rx_valid pulse.
`timescale 1ns/1ps
module tb_sspi_byte_slave;
    localparam int PH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sspi_cs, sspi_clk, sspi_mosi, sspi_miso;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_first, tx_req, cs_start, cs_end;

    int vectors = 0, miscompares = 0;
    int n_rxv = 0, n_txreq = 0, n_cs_start = 0, n_cs_end = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_e;

    sspi_byte_slave #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
        .clk(clk), .reset(reset), .sspi_cs(sspi_cs), .sspi_clk(sspi_clk),
        .sspi_mosi(sspi_mosi), .sspi_miso(sspi_miso), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_first(rx_first), .tx_req(tx_req),
        .tx_data(tx_data), .cs_start(cs_start), .cs_end(cs_end)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rxv++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $error("FAIL rx_unexpected got %h exp none", {rx_first, rx_data});
            end else begin
                exp_e = sb.pop_front();
                assert ({rx_first, rx_data} === exp_e) else begin
                    miscompares++;
                    $error("FAIL rx_byte got first/data %h exp %h", {rx_first, rx_data}, exp_e);
                end
            end
        end
        if (tx_req)   n_txreq++;
        if (cs_start) n_cs_start++;
        if (cs_end)   n_cs_end++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        sspi_cs = 1'b0;
        wc(8);
    endtask

    task automatic cs_high();
        wc(PH);
        sspi_cs = 1'b1;
        wc(8);
    endtask

    // Master samples MISO just before each rising SCLK edge.
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = 8'd0;
        for (int i = 0; i < n; i++) begin
            sspi_mosi = b[7-i];
            wc(PH);
            m = {m[6:0], sspi_miso};
            sspi_clk = 1'b1;
            wc(PH);
            sspi_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic first, output logic [7:0] m);
        sb.push_back({first, b});
        send_bits(b, 8, m);
    endtask

    initial begin
        int c_rxv, c_tx, c_cse, c_css;
        logic [7:0] m, rb;

        sspi_cs = 1'b1; sspi_clk = 1'b0; sspi_mosi = 1'b0; tx_data = 8'h00;
        reset = 1'b1;
        wc(3);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_pulses", {27'd0, rx_valid, rx_first, tx_req, cs_start, cs_end}, 32'h0);
        chk("rst_miso", {31'd0, sspi_miso}, 32'h0);
        reset = 1'b0;
        wc(5);

        // single byte frame
        c_rxv = n_rxv; c_cse = n_cs_end; c_css = n_cs_start;
        cs_low();
        send_byte(8'h01, 1'b1, m);
        cs_high();
        chk("t1_rxv", n_rxv - c_rxv, 1);
        chk("t1_cs_start", n_cs_start - c_css, 1);
        chk("t1_cs_end", n_cs_end - c_cse, 1);

        // command plus four data bytes
        c_rxv = n_rxv;
        cs_low();
        send_byte(8'h02, 1'b1, m);
        for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b0, m);
        cs_high();
        chk("t2_rxv", n_rxv - c_rxv, 5);

        // MISO serialisation
        tx_data = 8'h3C;
        c_tx = n_txreq;
        cs_low();
        send_byte(8'h00, 1'b1, m);
        cs_high();
        chk("t3_miso_byte", {24'd0, m}, 32'h3C);
        chk("t3_tx_req", n_txreq - c_tx, 2);
        chk("t3_miso_idle", {31'd0, sspi_miso}, 32'h0);

        // aborted partial byte, then clean frame
        c_rxv = n_rxv;
        cs_low();
        send_bits(8'hFF, 5, m);
        cs_high();
        chk("t4_partial_rxv", n_rxv - c_rxv, 0);
        cs_low();
        send_byte(8'h5A, 1'b1, m);
        cs_high();
        chk("t4_rx_data", {24'd0, rx_data}, 32'h5A);

        // reset mid-byte
        tx_data = 8'hFF;
        cs_low();
        send_bits(8'hFF, 3, m);
        reset = 1'b1;
        wc(2);
        chk("t5_rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("t5_rst_pulses", {27'd0, rx_valid, rx_first, tx_req, cs_start, cs_end}, 32'h0);
        chk("t5_rst_miso", {31'd0, sspi_miso}, 32'h0);
        reset = 1'b0;
        wc(10);
        sspi_cs = 1'b1;
        wc(10);
        cs_low();
        send_byte(8'hC3, 1'b1, m);
        cs_high();
        chk("t5_rx_data", {24'd0, rx_data}, 32'hC3);

        // 8th SCLK rise coincident with CS rise
        tx_data = 8'h00;
        c_rxv = n_rxv; c_tx = n_txreq; c_cse = n_cs_end;
        cs_low();
        sb.push_back({1'b1, 8'h96});
        send_bits(8'h96, 7, m);
        sspi_mosi = 1'b0;
        wc(PH);
        sspi_clk = 1'b1;
        sspi_cs  = 1'b1;
        wc(8);
        sspi_clk = 1'b0;
        wc(8);
        chk("t6_same_rxv", n_rxv - c_rxv, 1);
        chk("t6_same_cs_end", n_cs_end - c_cse, 1);
        chk("t6_same_tx_req", n_txreq - c_tx, 1);

        // long stream: cmd, 3 length bytes, 16 random bytes
        c_rxv = n_rxv;
        cs_low();
        send_byte(8'h07, 1'b1, m);
        send_byte(8'h00, 1'b0, m);
        send_byte(8'h00, 1'b0, m);
        send_byte(8'h10, 1'b0, m);
        rb = 8'h00;
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            tx_data = rb;
            send_byte(rb, 1'b0, m);
        end
        cs_high();
        chk("t6_stream_rxv", n_rxv - c_rxv, 20);
        chk("t6_last_data", {24'd0, rx_data}, {24'd0, rb});
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
